tt_um_delta_sigma_adc: RTL and testbench
========================================

// Module: tt_um_delta_sigma_adc
// PURPOSE
//  Decimating receiver for a 1-bit delta-sigma bitstream; the inverse of the delta-sigma DAC.
//  Cascaded integrator-comb (CIC) filter, order N=2 by default, decimation ratio R=2^LOG2R.
//  Produces signed BW-bit PCM samples at clk_i/R behind a one-entry valid/ready output register.
//  Sits between an external modulator/comparator bit input and downstream sample consumers.
// PARAMETERS
//  BW     14  output sample width (signed); matches the DAC input width
//  LOG2R   7  log2 of decimation ratio R (R=128); requires N*LOG2R >= BW-1
// PORTS
//  clk_i       in   1   system clock; bit_i sampled every rising edge
//  rst_i       in   1   reset, asynchronous assert, active-low
//  bit_i       in   1   delta-sigma bitstream; 1 -> +1, 0 -> -1
//  sample_o    out  BW  signed decimated sample, two's complement
//  valid_o     out  1   sample_o holds an unconsumed sample
//  ready_i     in   1   consumer accepts sample_o when valid_o && ready_i
//  overrun_o   out  1   one-cycle pulse: an unconsumed sample was overwritten
// BEHAVIOUR
//  Reset (rst_i=0, async): integrators, combs, decimation counter, warm-up counter cleared;
//   sample_o=0, valid_o=0, overrun_o=0. Effective on the first edge after rst_i returns to 1.
//  Arithmetic: internal width W = N*LOG2R+2 bits, two's complement. Integrator and comb
//   wrap-around is modular and intentional; no saturation inside the filter.
//  Integrators: every cycle, I1 += (bit_i ? +1 : -1); Ik += I(k-1) for k=2..N, in parallel.
//  Decimation counter dec_cnt: counts 0..R-1, wraps to 0; increments every cycle.
//  Decimate: on the edge where dec_cnt==R-1, comb chain Ck = x - x_prev(k) is evaluated
//   on the integrator value including that cycle's bit. Comb delay registers update.
//  Scaling: y = C_N >>> (N*LOG2R-(BW-1)), arithmetic shift. Saturate to [-2^(BW-1), 2^(BW-1)-1].
//   Full-scale +R^N maps to 2^(BW-1)-1.
//  Warm-up: first N decimated results after reset are discarded; no valid_o, no overrun_o.
//  Output register: a kept result loads sample_o and sets valid_o on the same edge.
//   valid_o is therefore high from the cycle after dec_cnt==R-1.
//  Handshake: valid_o clears on an edge where valid_o && ready_i, unless a new result loads.
//   If a new result loads on that same edge, valid_o stays 1 with the new sample.
//  Overrun: result loads while valid_o=1 && ready_i=0 -> overwrite sample_o; overrun_o=1 for one cycle.
//  sample_o is stable while valid_o=1 and no new result loads.
//  Latency: input bit to first influence on sample_o is at most R cycles. Group delay is N*(R-1)/2 input samples.
// CONFIGURATION
//  DS_ADC_SINC3_EN defined: N=3 (third integrator and comb stage), W=3*LOG2R+2, shift=3*LOG2R-(BW-1).
//   Warm-up is 3 outputs.
//  Not defined: N=2 as above. All ports and the handshake are identical in both builds.
// TESTING
//  All-ones bit_i, ready_i=1 -> after warm-up every sample_o=8191 (saturated +2^14), valid_o once per 128 cycles.
//  All-zeros -> sample_o=-8192 steady.
//  Alternating 1,0 -> sample_o=0 steady.
//  Repeating 1,1,1,0 -> sample_o=4096 steady.
//  ready_i=0 for 300 cycles with steady input -> overrun_o pulses at 2nd and 3rd new result;
//   sample_o shows newest value; ready_i=1 -> valid_o drops next edge.
//  rst_i=0 at dec_cnt=60 mid-frame -> outputs 0 immediately. After release: warm-up repeats;
//   first valid_o comes 128*(N+1) cycles later.
//  Repeat the all-ones, alternating and 1,1,1,0 cases with DS_ADC_SINC3_EN -> same steady values.
//   Warm-up is 3 frames.

Source files
------------

// File: rtl/tt_um_delta_sigma_adc.sv
// tt_um_delta_sigma_adc: CIC decimator (sinc2, or sinc3 when DS_ADC_SINC3_EN is defined) turning a 1-bit delta-sigma stream into signed PCM.
// Output sits behind a one-entry valid/ready register with an overrun pulse.
module tt_um_delta_sigma_adc #(
  parameter int BW    = 14,
  parameter int LOG2R = 7
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 bit_i,
  input  logic                 ready_i,
  output logic signed [BW-1:0] sample_o,
  output logic                 valid_o,
  output logic                 overrun_o
);
`ifdef DS_ADC_SINC3_EN
  localparam int N = 3;
`else
  localparam int N = 2;
`endif
  localparam int W  = N * LOG2R + 2;
  localparam int SH = N * LOG2R - (BW - 1);
  localparam logic signed [W-1:0] ONE   = W'(1);
  localparam logic signed [W-1:0] P_MAX = W'((1 << (BW - 1)) - 1);
  localparam logic signed [W-1:0] P_MIN = -P_MAX - ONE;
  localparam logic [LOG2R-1:0]    DEC_ONE = LOG2R'(1);
  localparam logic [1:0]          WARM    = 2'(N);

  logic signed [W-1:0]  r_int [N];
  logic signed [W-1:0]  r_dly [N];
  logic signed [W-1:0]  w_int_nx [N];
  logic signed [W-1:0]  w_cmb [N];
  logic signed [W-1:0]  w_sh, w_sat;
  logic [LOG2R-1:0]     r_dec;
  logic [1:0]           r_warm;
  logic signed [BW-1:0] r_sample;
  logic                 r_valid, r_ovr;
  logic                 w_dec, w_keep;

  // Integrators update in parallel; the comb sees the last integrator's next value.
  always_comb begin
    w_int_nx[0] = r_int[0] + (bit_i ? ONE : -ONE);
    for (int k = 1; k < N; k++) w_int_nx[k] = r_int[k] + r_int[k-1];
    w_cmb[0] = w_int_nx[N-1] - r_dly[0];
    for (int k = 1; k < N; k++) w_cmb[k] = w_cmb[k-1] - r_dly[k];
    w_sh  = w_cmb[N-1] >>> SH;
    w_sat = (w_sh > P_MAX) ? P_MAX : (w_sh < P_MIN) ? P_MIN : w_sh;
  end

  assign w_dec  = &r_dec;
  assign w_keep = w_dec && (r_warm == WARM);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int k = 0; k < N; k++) begin
        r_int[k] <= '0;
        r_dly[k] <= '0;
      end
      r_dec    <= '0;
      r_warm   <= '0;
      r_sample <= '0;
      r_valid  <= 1'b0;
      r_ovr    <= 1'b0;
    end else begin
      for (int k = 0; k < N; k++) r_int[k] <= w_int_nx[k];
      r_dec <= r_dec + DEC_ONE;
      if (w_dec) begin
        r_dly[0] <= w_int_nx[N-1];
        for (int k = 1; k < N; k++) r_dly[k] <= w_cmb[k-1];
      end
      if (w_dec && !w_keep) r_warm <= r_warm + 2'd1;
      if (w_keep) r_sample <= BW'(w_sat);
      r_valid <= w_keep | (r_valid & ~ready_i);
      r_ovr   <= w_keep & r_valid & ~ready_i;
    end
  end

  assign sample_o  = r_sample;
  assign valid_o   = r_valid;
  assign overrun_o = r_ovr;
endmodule

// File: tb/tb_tt_um_delta_sigma_adc.sv
// tb_tt_um_delta_sigma_adc: randomized bench with an impulse-response reference model of the CIC decimator.
// Honours DS_ADC_SINC3_EN the same way the design does.
module tb_tt_um_delta_sigma_adc;
`ifdef DS_ADC_SINC3_EN
  localparam int N = 3;
`else
  localparam int N = 2;
`endif
  localparam int BW = 14;
  localparam int LOG2R = 7;
  localparam int R = 1 << LOG2R;
  localparam int SH = N * LOG2R - (BW - 1);
  localparam int YMAX = (1 << (BW - 1)) - 1;
  localparam int YMIN = -(1 << (BW - 1));

  logic clk_i = 1'b0, rst_i = 1'b0, bit_i = 1'b0, ready_i = 1'b0;
  logic signed [BW-1:0] sample_o;
  logic valid_o, overrun_o;

  tt_um_delta_sigma_adc #(.BW(BW), .LOG2R(LOG2R)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .bit_i(bit_i), .sample_o(sample_o),
    .valid_o(valid_o), .ready_i(ready_i), .overrun_o(overrun_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk = 0, n_err = 0;
  int h [0:1023];
  int hl;
  int hist [$];
  int t = 0;
  int ev = 0, es = 0, eo = 0;
  int ovr_seen = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s t=%0d got %0d exp %0d", tag, t, got, exp);
    end
  endtask

  // Filter impulse response: boxcar of length R convolved N times, delayed N-1 samples.
  task automatic build_h();
    int tmp [0:1023];
    hl = R;
    for (int i = 0; i < 1024; i++) h[i] = (i < R) ? 1 : 0;
    for (int s = 1; s < N; s++) begin
      for (int i = 0; i < 1024; i++) tmp[i] = 0;
      for (int i = 0; i < hl; i++)
        for (int j = 0; j < R; j++) tmp[i+j] += h[i];
      hl += R - 1;
      for (int i = 0; i < 1024; i++) h[i] = tmp[i];
    end
  endtask

  task automatic model(input int b, input int r);
    int c, y;
    hist.push_back(b ? 1 : -1);
    if (t % R == R - 1 && t / R >= N) begin
      c = 0;
      for (int d = 0; d < hl; d++)
        if (t - (N - 1) - d >= 0) c += h[d] * hist[t - (N - 1) - d];
      y = c >>> SH;
      y = (y > YMAX) ? YMAX : (y < YMIN) ? YMIN : y;
      eo = (ev != 0 && r == 0) ? 1 : 0;
      ev = 1;
      es = y;
    end else begin
      eo = 0;
      if (ev != 0 && r != 0) ev = 0;
    end
  endtask

  task automatic step(input logic b, input logic r);
    bit_i = b;
    ready_i = r;
    @(posedge clk_i);
    model(int'(b), int'(r));
    t++;
    @(negedge clk_i);
    chk("valid", int'(valid_o), ev);
    chk("sample", int'(sample_o), es);
    chk("overrun", int'(overrun_o), eo);
    if (overrun_o) ovr_seen++;
  endtask

  function automatic logic pat(input int mode, input int tt);
    case (mode)
      0: pat = 1'b1;
      1: pat = 1'b0;
      2: pat = (tt % 2 == 0);
      3: pat = (tt % 4 != 3);
      default: pat = 1'(($urandom >> 3) & 1);
    endcase
  endfunction

  task automatic run(input int n, input int mode, input int rmode);
    for (int i = 0; i < n; i++)
      step(pat(mode, t), (rmode == 0) ? 1'b1 : (rmode == 1) ? 1'b0 : 1'($urandom & 1));
  endtask

  task automatic do_reset();
    rst_i = 1'b0;
    #1;
    chk("rst_valid", int'(valid_o), 0);
    chk("rst_sample", int'(sample_o), 0);
    chk("rst_overrun", int'(overrun_o), 0);
    hist.delete();
    t = 0; ev = 0; es = 0; eo = 0;
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;
  endtask

  initial begin
    int n;
    build_h();
    @(negedge clk_i);
    do_reset();
    run(6 * R, 0, 0);
    chk("ones", int'(sample_o), 8191);
    run(5 * R, 1, 0);
    chk("zeros", int'(sample_o), -8192);
    run(5 * R, 2, 0);
    chk("alt", int'(sample_o), 0);
    run(5 * R, 3, 0);
    chk("p1110", int'(sample_o), 4096);
    run(10 * R, 4, 2);
    run(3 * R, 3, 0);
    while (t % R != R - 2) step(1'b1, 1'b1);
    ovr_seen = 0;
    run(300, 0, 1);
    chk("ovr_count", ovr_seen, 2);
    chk("newest", int'(sample_o), 8191);
    step(1'b1, 1'b1);
    chk("drop", int'(valid_o), 0);
    while (t % R != 60) step(1'b1, 1'b1);
    do_reset();
    n = 0;
    while (!valid_o && n < 1000) begin
      step(1'b1, 1'b1);
      n++;
    end
    chk("first_valid", n, R * (N + 1));
    run(8 * R, 4, 2);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
